io_debounce: RTL and testbench
==============================

IO_DEBOUNCE -- requirements
Module: io_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clk cycles per debounce sample tick, legal range >=1.
REQ-002 SHALL have parameter STABLE_TICKS, default 8: consecutive ticks of stable mismatch needed to accept a new level, legal range >=1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state in this domain.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port buttons_raw, input, 5 bits: asynchronous push-button pins.
REQ-006 SHALL have port switches_raw, input, 16 bits: asynchronous slide-switch pins.
REQ-007 SHALL have port buttons, output, 5 bits: debounced button levels, fed to the bus IO slave buttons input.
REQ-008 SHALL have port switches, output, 16 bits: debounced switch levels, fed to the bus IO slave switches input.
REQ-009 SHALL have port btn_rise, output, 5 bits: one-cycle pulse per button on a debounced 0->1 transition.
REQ-010 SHALL have port sw_change, output, 1 bit: one-cycle pulse when any debounced switch bit changes.

Function
REQ-011 SHALL pass each of the 21 raw bits through a 2-flop synchronizer before any other logic.
REQ-012 SHALL run a prescaler counting 0..TICK_DIV-1 that wraps to 0; tick is asserted for the one cycle where the count equals TICK_DIV-1; TICK_DIV=1 means tick is asserted every cycle.
REQ-013 SHALL keep, per bit, a stable level and a counter of width clog2(STABLE_TICKS+1).
REQ-014 On a tick where the synced bit differs from the stable level, the counter SHALL increment.
REQ-015 On the tick where that increment would reach STABLE_TICKS, the stable level SHALL take the synced value and the counter SHALL clear to 0.
REQ-016 On a tick where the synced bit equals the stable level, the counter SHALL clear to 0, so glitches shorter than STABLE_TICKS ticks are rejected.
REQ-017 Counters SHALL hold their value on non-tick cycles.
REQ-018 buttons and switches SHALL be registered copies of the stable levels.
REQ-019 Latency from a clean raw edge SHALL be 2 synchronizer cycles, plus the wait to the next tick, plus (STABLE_TICKS-1)*TICK_DIV cycles, plus 1 register cycle.
REQ-020 btn_rise[i] SHALL be high for exactly the first cycle on which buttons[i] is 1 after being 0.
REQ-021 No btn_rise pulse SHALL be generated on a 1->0 transition.
REQ-022 sw_change SHALL be high for exactly the first cycle on which switches differs from its previous-cycle value.
REQ-023 sw_change SHALL be a single pulse when several switch bits change on the same cycle.
REQ-024 Bits SHALL debounce independently; simultaneous transitions on different bits SHALL each follow REQ-014..REQ-016 unaffected by one another.

Reset
REQ-025 While rst_n=0 the following SHALL be 0: synchronizer flops, prescaler, per-bit counters, stable levels, buttons, switches, btn_rise and sw_change.
REQ-026 After release, pins already high SHALL appear high only after full debounce per REQ-019, with btn_rise/sw_change pulsing once.
REQ-027 Asserting rst_n mid-debounce SHALL discard all partial counts immediately.

Configuration
REQ-028 With macro IO_DEBOUNCE_EDGE_EN defined, btn_rise and sw_change SHALL be generated per REQ-020..REQ-023.
REQ-029 Without IO_DEBOUNCE_EDGE_EN, btn_rise and sw_change SHALL be tied to 0, their edge-detect registers SHALL be absent, and buttons/switches behaviour SHALL be unchanged.

Verification (TICK_DIV=4, STABLE_TICKS=3, IO_DEBOUNCE_EDGE_EN defined)
REQ-030 Reset hold then release with raw all 0 -> buttons=0, switches=0, btn_rise=0, sw_change=0 for 100 cycles.
REQ-031 buttons_raw[2] 0->1 held -> buttons[2]=1 within 2+4+8+1=15 cycles; btn_rise=5'b00100 for exactly one cycle.
REQ-032 buttons_raw[0] high for 6 cycles then low -> buttons[0] stays 0 and btn_rise[0] never pulses.
REQ-033 switches_raw 0x0000->0xFFFF in one cycle -> switches=0xFFFF on a single cycle and sw_change pulses once.
REQ-034 buttons_raw=5'b10101 settled, then reset during a later 1->0 debounce -> all outputs 0 during reset; after release buttons returns to 5'b10101 with one btn_rise=5'b10101 pulse.
REQ-035 Settled buttons=1 then raw 1->0 -> buttons drops after debounce with no btn_rise pulse.

Source files
------------

// File: rtl/io_debounce.sv
// io_debounce: sync, tick-sampled debounce of 5 buttons and 16 switches.
// Optional edge outputs are enabled with macro IO_DEBOUNCE_EDGE_EN.
module io_debounce #(
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  buttons_raw,
  input  logic [15:0] switches_raw,
  output logic [4:0]  buttons,
  output logic [15:0] switches,
  output logic [4:0]  btn_rise,
  output logic        sw_change
);

  localparam int NB = 21;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q, s1_d;
  logic [NB-1:0] s2_q, s2_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [NB-1:0] stable_q, stable_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NB-1:0] out_q, out_d;

  assign raw = {switches_raw, buttons_raw};

  // two-flop synchronizer on every raw pin
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
  end

  // prescaler wraps at TICK_DIV-1; tick marks the wrap cycle
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // per-bit mismatch counter; a full run of ticks adopts the new level
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]    = '0;
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // output register decouples the stable levels from the consumers
  always_comb begin
    out_d = stable_q;
  end

  // all debounce state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      pre_q    <= '0;
      stable_q <= '0;
      out_q    <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      pre_q    <= pre_d;
      stable_q <= stable_d;
      out_q    <= out_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign buttons  = out_q[4:0];
  assign switches = out_q[20:5];

`ifdef IO_DEBOUNCE_EDGE_EN
  logic [NB-1:0] prev_q, prev_d;

  // previous-cycle copy of the outputs for edge detection
  always_comb begin
    prev_d = out_q;
  end

  // edge history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign btn_rise  = out_q[4:0] & ~prev_q[4:0];
  assign sw_change = |(out_q[20:5] ^ prev_q[20:5]);
`else
  assign btn_rise  = '0;
  assign sw_change = 1'b0;
`endif

endmodule

// File: tb/tb_io_debounce.sv
// tb_io_debounce: directed vectors and corner sequences for io_debounce.
// Edge expectations follow whether IO_DEBOUNCE_EDGE_EN is defined.
module tb_io_debounce;

`ifdef IO_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  buttons_raw;
  logic [15:0] switches_raw;
  logic [4:0]  buttons;
  logic [15:0] switches;
  logic [4:0]  btn_rise;
  logic        sw_change;

  io_debounce #(
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttons_raw  (buttons_raw),
    .switches_raw (switches_raw),
    .buttons      (buttons),
    .switches     (switches),
    .btn_rise     (btn_rise),
    .sw_change    (sw_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int rise_tot [5];
  int swc_tot;
  int rise_base [5];
  int swc_base;
  int tests;
  int fails;

  initial begin
    for (int i = 0; i < 5; i++) rise_tot[i] = 0;
    swc_tot = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (btn_rise[i] === 1'b1) rise_tot[i] = rise_tot[i] + 1;
    end
    if (sw_change === 1'b1) swc_tot = swc_tot + 1;
  end

  typedef struct {
    logic [4:0]  btn_in;
    logic [15:0] sw_in;
    logic [4:0]  exp_btn;
    logic [15:0] exp_sw;
    logic [4:0]  exp_rise;
    int          exp_swc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 5; i++) rise_base[i] = rise_tot[i];
    swc_base = swc_tot;
  endtask

  // bit i set if exactly one pulse; high half flags extra pulses
  function automatic logic [9:0] rise_got();
    logic [9:0] r;
    int d;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      d = rise_tot[i] - rise_base[i];
      if (d == 1) r[i] = 1'b1;
      if (d > 1) r[5+i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [4:0] er(input logic [4:0] m);
    return EDGE ? m : 5'b0;
  endfunction

  int n;
  int bad;
  logic [4:0] rise_at;
  logic seen;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{5'b00100, 16'hFFFF, 5'b00100, 16'hFFFF, 5'b00000, 1};
    vecs[1] = '{5'b10101, 16'hA5A5, 5'b10101, 16'hA5A5, 5'b10001, 1};
    vecs[2] = '{5'b00001, 16'hA5A5, 5'b00001, 16'hA5A5, 5'b00000, 0};
    vecs[3] = '{5'b00000, 16'h0000, 5'b00000, 16'h0000, 5'b00000, 1};
    vecs[4] = '{5'b11111, 16'h0001, 5'b11111, 16'h0001, 5'b11111, 1};
    vecs[5] = '{5'b00000, 16'h0001, 5'b00000, 16'h0001, 5'b00000, 0};

    rst_n = 1'b0;
    buttons_raw = '0;
    switches_raw = '0;
    cyc(5);
    chk("reset_out", {btn_rise, sw_change, buttons, switches}, 32'h0);

    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      cyc(1);
      if ({btn_rise, sw_change, buttons, switches} !== '0) bad++;
    end
    chk("idle100", bad, 0);

    snap();
    buttons_raw = 5'b00100;
    n = 0;
    rise_at = '0;
    while (buttons[2] !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
      if (buttons[2] === 1'b1) rise_at = btn_rise;
    end
    chk("lat_range", {31'b0, (n >= 12 && n <= 15)}, 1);
    chk("rise_val", rise_at, er(5'b00100));
    cyc(1);
    chk("rise_width", btn_rise, 0);
    cyc(30);
    chk("rise_once", rise_got(), {5'b0, er(5'b00100)});

    for (int v = 0; v < 6; v++) begin
      snap();
      buttons_raw = vecs[v].btn_in;
      switches_raw = vecs[v].sw_in;
      cyc(40);
      chk($sformatf("v%0d_btn", v), buttons, vecs[v].exp_btn);
      chk($sformatf("v%0d_sw", v), switches, vecs[v].exp_sw);
      chk($sformatf("v%0d_rise", v), rise_got(),
          {5'b0, er(vecs[v].exp_rise)});
      chk($sformatf("v%0d_swc", v), swc_tot - swc_base,
          EDGE ? vecs[v].exp_swc : 0);
    end

    snap();
    buttons_raw[0] = 1'b1;
    cyc(6);
    buttons_raw[0] = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      cyc(1);
      if (buttons[0] !== 1'b0) seen = 1'b1;
    end
    chk("glitch_btn", seen, 0);
    chk("glitch_rise", rise_got(), 0);

    buttons_raw = 5'b10101;
    switches_raw = 16'h0000;
    cyc(40);
    chk("pre_rst_btn", buttons, 5'b10101);
    buttons_raw = 5'b00000;
    cyc(9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {btn_rise, sw_change, buttons, switches}, 0);
    buttons_raw = 5'b10101;
    cyc(5);
    chk("hold_rst_out", {btn_rise, sw_change, buttons, switches}, 0);
    snap();
    rst_n = 1'b1;
    cyc(40);
    chk("post_rst_btn", buttons, 5'b10101);
    chk("post_rst_rise", rise_got(), {5'b0, er(5'b10101)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
